uart_msg_reader: RTL and testbench

Streaming reader that pulls a byte message out of the 512x8 block RAM over its one-cycle-latency read port and presents it, one byte per handshake, to the UART transmitter's valid/ready input. It sits between the message RAM and the UART TX path. Software or a control FSM supplies a start address and length. The block sustains one byte per cycle when the transmitter is always ready and never drops or duplicates a byte under backpressure.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_msg_reader_skid_buf.sv | 54 +++++
 rtl/uart_msg_reader.sv | 124 ++++++++++++
 tb/tb_uart_msg_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART message reader
package uart_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int LEN_W_DEF  = 10;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_CSUM,
        ST_FIN
    } state_t;

endpackage

// File: rtl/uart_msg_reader_skid_buf.sv
// rtl/uart_msg_reader_skid_buf.sv - two-entry byte FIFO between RAM read data and the TX handshake
module byte_skid_buf
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  byte_t      data_i,
    input  logic       pop_i,
    output byte_t      data_o,
    output logic [1:0] count_o
);

    byte_t      head_q;
    byte_t      tail_q;
    logic [1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= data_i;
                    else                 tail_q <= data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new byte lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        head_q <= data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_o  = head_q;
    assign count_o = count_q;

    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && !pop_i && count_q == 2'd2));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/uart_msg_reader.sv
// rtl/uart_msg_reader.sv - streams a RAM message to the UART TX handshake; UART_READER_CHECKSUM_EN appends a sum byte
module uart_msg_reader
    import uart_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_raddr,
    input  byte_t             mem_rdata,
    output logic              tx_valid,
    output byte_t             tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    state_t            state_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              inflight_q;

    logic [1:0] buf_count;
    byte_t      buf_data;
    logic       pop;
    logic       buf_pop;
    logic [2:0] occupancy;
    logic       in_csum;
    byte_t      csum_value;

`ifdef UART_READER_CHECKSUM_EN
    byte_t csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (state_q == ST_IDLE) begin
            csum_q <= '0;
        end else if (buf_pop) begin
            csum_q <= csum_q + buf_data;
        end
    end

    assign in_csum    = (state_q == ST_CSUM);
    assign csum_value = csum_q;
`else
    assign in_csum    = 1'b0;
    assign csum_value = '0;
`endif

    assign pop     = tx_valid && tx_ready;
    assign buf_pop = pop && (buf_count != 2'd0);

    // Bytes buffered or on their way after this cycle's pop; a new read may only go out if a slot is free.
    assign occupancy   = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, buf_pop};
    assign mem_read_en = (state_q == ST_READ) && (remaining_q != '0) && (occupancy < 3'd2);
    assign mem_raddr   = raddr_q;

    byte_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .data_i  (mem_rdata),
        .pop_i   (buf_pop),
        .data_o  (buf_data),
        .count_o (buf_count)
    );

    assign tx_valid = (buf_count != 2'd0) || in_csum;
    assign tx_data  = (buf_count != 2'd0) ? buf_data : csum_value;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            raddr_q     <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= mem_read_en;
            if (mem_read_en) begin
                raddr_q     <= raddr_q + ADDR_W'(1);
                remaining_q <= remaining_q - LEN_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        raddr_q     <= base_addr;
                        remaining_q <= len;
                        // An empty message skips reading; DRAIN sees an empty buffer and finishes next cycle.
                        state_q     <= (len == '0) ? ST_DRAIN : ST_READ;
                    end
                end
                ST_READ: begin
                    if (remaining_q == '0 || (remaining_q == LEN_W'(1) && mem_read_en))
                        state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (occupancy == 3'd0) begin
`ifdef UART_READER_CHECKSUM_EN
                        state_q <= ST_CSUM;
`else
                        state_q <= ST_FIN;
`endif
                    end
                end
`ifdef UART_READER_CHECKSUM_EN
                ST_CSUM: begin
                    if (pop) state_q <= ST_FIN;
                end
`endif
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_reader.sv
// tb/tb_uart_msg_reader.sv - directed self-checking bench for uart_msg_reader
module tb_uart_msg_reader;
    import uart_pkg::*;

`ifdef UART_READER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] base_addr = '0;
    logic [9:0] len = '0;
    logic       mem_read_en;
    logic [8:0] mem_raddr;
    logic [7:0] mem_rdata = '0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       done;

    logic [7:0] mem [512];
    int n_pass = 0;
    int n_chk  = 0;
    int cyc = 0;
    int t0  = 0;

    logic [7:0] hs_data [$];
    int         hs_cyc  [$];
    logic [8:0] rd_addr [$];
    int         done_cyc = -1;
    int         busy_cyc = -1;
    int         stab_viol = 0;
    int         rule_viol = 0;
    int         outstanding = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = '0;
    logic [3:0] pat = 4'b1001;

    uart_msg_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .mem_read_en (mem_read_en),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        if (mem_read_en) mem_rdata <= mem[mem_raddr];
    end

    initial forever begin
        int pd;
        @(negedge clk);
        if (rst_n) begin
            pd = (tx_valid && tx_ready && outstanding > 0) ? 1 : 0;
            if (busy && busy_cyc < 0) busy_cyc = cyc - t0;
            if (done && done_cyc < 0) done_cyc = cyc - t0;
            if (hold_v && !(tx_valid && tx_data == hold_d)) stab_viol++;
            if (mem_read_en) begin
                if (outstanding - pd >= 2) rule_viol++;
                rd_addr.push_back(mem_raddr);
            end
            if (tx_valid && tx_ready) begin
                hs_data.push_back(tx_data);
                hs_cyc.push_back(cyc - t0);
            end
            outstanding = outstanding + (mem_read_en ? 1 : 0) - pd;
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] hs_at(input int k);
        return (k < hs_data.size()) ? 32'(hs_data[k]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] hc_at(input int k);
        return (k < hs_cyc.size()) ? 32'(hs_cyc[k]) : 32'hFFFF_FFFF;
    endfunction

    task automatic run(input logic [8:0] b, input logic [9:0] l, input bit bp, input bit glitch);
        hs_data.delete();
        hs_cyc.delete();
        rd_addr.delete();
        done_cyc = -1;
        busy_cyc = -1;
        stab_viol = 0;
        rule_viol = 0;
        outstanding = 0;
        hold_v = 1'b0;
        @(posedge clk); #1;
        t0 = cyc;
        base_addr = b;
        len = l;
        start = 1'b1;
        tx_ready = 1'b1;
        for (int i = 1; i < 4 * int'(l) + 40 && done_cyc < 0; i++) begin
            @(posedge clk); #1;
            start = glitch && (i == 1);
            if (glitch) begin
                base_addr = 9'h0AA;
                len = 10'd3;
            end
            tx_ready = bp ? pat[i % 4] : 1'b1;
        end
        tx_ready = 1'b1;
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
    endtask

    initial begin
        logic [7:0] hello [5];
        int bad;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 5; i++) mem[9'h010 + i] = hello[i];
        mem[9'h1FE] = 8'hA0;
        mem[9'h1FF] = 8'hA1;
        mem[9'h000] = 8'hA2;
        mem[9'h001] = 8'hA3;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read_en", 32'(mem_read_en), 32'd0);
        check("rst_raddr", 32'(mem_raddr), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(9'h010, 10'd5, 1'b0, 1'b0);
        check("hello_busy_cyc", 32'(busy_cyc), 32'd1);
        check("hello_first_raddr", (rd_addr.size() > 0) ? 32'(rd_addr[0]) : 32'hFFFF_FFFF, 32'h010);
        check("hello_reads", 32'(rd_addr.size()), 32'd5);
        check("hello_count", 32'(hs_data.size()), 32'(5 + CS));
        for (int k = 0; k < 5; k++) begin
            check("hello_byte", hs_at(k), 32'(hello[k]));
            check("hello_cyc", hc_at(k), 32'(3 + k));
        end
`ifdef UART_READER_CHECKSUM_EN
        check("hello_csum", hs_at(5), 32'h74);
        check("hello_csum_cyc", hc_at(5), 32'd8);
`endif
        check("hello_done_cyc", 32'(done_cyc), 32'(8 + CS));

        run(9'h1FE, 10'd4, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("wrap_raddr", (k < rd_addr.size()) ? 32'(rd_addr[k]) : 32'hFFFF_FFFF,
                  32'((9'h1FE + 9'(k)) & 9'h1FF));
            check("wrap_byte", hs_at(k), 32'(8'hA0 + 8'(k)));
        end

        run(9'h080, 10'd8, 1'b1, 1'b0);
        check("bp_count", 32'(hs_data.size()), 32'(8 + CS));
        for (int k = 0; k < 8; k++) check("bp_byte", hs_at(k), 32'(mem[9'h080 + k]));
        check("bp_stable", 32'(stab_viol), 32'd0);
        check("bp_issue_rule", 32'(rule_viol), 32'd0);

        run(9'h020, 10'd0, 1'b0, 1'b1);
        check("len0_busy_cyc", 32'(busy_cyc), 32'd1);
        check("len0_done_cyc", 32'(done_cyc), 32'(2 + CS));
        check("len0_tx_count", 32'(hs_data.size()), 32'(CS));
        @(negedge clk);
        check("len0_idle_after", 32'(busy), 32'd0);
        check("len0_no_reads", 32'(rd_addr.size()), 32'd0);

        run(9'h123, 10'd512, 1'b0, 1'b0);
        check("full_reads", 32'(rd_addr.size()), 32'd512);
        check("full_count", 32'(hs_data.size()), 32'(512 + CS));
        bad = 0;
        for (int k = 0; k < 512; k++)
            if (hs_at(k) !== 32'(mem[(9'h123 + k) % 512])) bad++;
        check("full_bytes", 32'(bad), 32'd0);

        @(posedge clk); #1;
        t0 = cyc;
        base_addr = 9'h040;
        len = 10'd20;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_pre_valid", 32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_read_en", 32'(mem_read_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        check("mid_hold_valid", 32'(tx_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_idle", 32'(busy | tx_valid), 32'd0);
        run(9'h100, 10'd2, 1'b0, 1'b0);
        check("post_rst_first", hs_at(0), 32'(mem[9'h100]));
        check("post_rst_count", 32'(hs_data.size()), 32'(2 + CS));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
